// File: rtl/spi_slave_rx.sv
// spi_slave_rx: receive-only SPI slave (mode 0, MSB first).
// sclk/ss/mosi are asynchronous to clk and are oversampled after a
// synchroniser chain; each completed word is presented on data_out with a
// valid/ready handshake, and dropped or truncated words are flagged by pulses.
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    input  logic                  data_ready,
    output logic                  overrun,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] ST_WAIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RECV = 2'd2;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sclk_d;
    logic                   rise;

    logic [1:0]            state;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-2:0] shreg;
    logic [DATA_WIDTH-1:0] word;

    // Synchronise the three SPI pins; ss resets to the asserted level so a
    // frame already in flight at reset release keeps the FSM in WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Delayed copy of synchronised sclk for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_d <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
        end
    end

    assign rise = sclk_s & ~sclk_d;

    // Only the low W-1 bits of history are kept; the MSB of a word is the
    // oldest stored bit and the LSB is the bit arriving on the final rise.
    assign word = {shreg, mosi_s};
    assign busy = (state == ST_RECV);

    // Frame FSM, bit shifting, output holding register and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_WAIT;
            bit_cnt    <= '0;
            shreg      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
            case (state)
                ST_WAIT: begin
                    if (ss_s) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (!ss_s) begin
                        state   <= ST_RECV;
                        bit_cnt <= '0;
                    end
                end
                ST_RECV: begin
                    if (ss_s) begin
                        state   <= ST_IDLE;
                        bit_cnt <= '0;
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                    end else if (rise) begin
                        shreg <= word[DATA_WIDTH-2:0];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (!data_valid || data_ready) begin
                                data_out   <= word;
                                data_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: drives an SPI master waveform into two receivers (2 and 3
// synchroniser stages) and checks them against a word-level model of what
// the master sent and what the consumer has taken.
module tb_spi_slave_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       ss;
    logic       mosi;
    logic       data_ready;
    logic [7:0] data_out0, data_out1;
    logic       valid0, valid1;
    logic       ovr0, ovr1;
    logic       ferr0, ferr1;
    logic       busy0, busy1;

    int tests_run    = 0;
    int tests_failed = 0;

    // Word-level model: every word the receivers must deliver, in order,
    // plus a per-receiver read pointer advanced on each accepted beat.
    logic [7:0] words[$];
    int         idx[2];
    int         ovr_seen[2];
    int         ferr_seen[2];
    logic       prev_vr[2];
    logic       prev_ovr[2];
    logic       prev_ferr[2];
    logic [7:0] last_beat[2];
    int         ovr_exp;
    int         ferr_exp;
    bit         waiting;
    int         bit_count;
    logic [7:0] cur_word;
    int         lat0, lat1;

    // 10 ns system clock.
    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .data_out(data_out0), .data_valid(valid0), .data_ready(data_ready),
        .overrun(ovr0), .frame_err(ferr0), .busy(busy0)
    );

    spi_slave_rx #(.DATA_WIDTH(8), .SYNC_STAGES(3)) dut3 (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .data_out(data_out1), .data_valid(valid1), .data_ready(data_ready),
        .overrun(ovr1), .frame_err(ferr1), .busy(busy1)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkDut(input int k, input logic [7:0] dout, input logic vld,
                            input logic ovr, input logic ferr, input logic rdy);
        if (vld) begin
            if (idx[k] >= words.size()) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL spurious_valid_dut%0d: got valid=1 data=0x%0h, expected valid=0",
                         k, dout);
            end else begin
                checkOutput($sformatf("data_dut%0d_word%0d", k, idx[k]), dout, words[idx[k]]);
                if (rdy) begin
                    last_beat[k] = dout;
                    idx[k]++;
                end
            end
        end
        if (prev_vr[k]) checkOutput($sformatf("valid_clear_dut%0d", k), vld, 0);
        if (prev_ovr[k]) checkOutput($sformatf("overrun_pulse_dut%0d", k), ovr, 0);
        if (prev_ferr[k]) checkOutput($sformatf("frame_err_pulse_dut%0d", k), ferr, 0);
        if (ovr && !prev_ovr[k]) ovr_seen[k]++;
        if (ferr && !prev_ferr[k]) ferr_seen[k]++;
        prev_vr[k]   = vld & rdy;
        prev_ovr[k]  = ovr;
        prev_ferr[k] = ferr;
    endtask

    // Compare both receivers against the model on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            checkDut(0, data_out0, valid0, ovr0, ferr0, data_ready);
            checkDut(1, data_out1, valid1, ovr1, ferr1, data_ready);
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // One SPI bit: data set while sclk is low, sampled on the rise.
    task automatic sendBit(input logic b, input bit measure);
        mosi = b;
        waitClk(8);
        sclk = 1'b1;
        if (!waiting) begin
            bit_count++;
            cur_word = {cur_word[6:0], b};
            if (bit_count % 8 == 0) begin
                if (idx[0] >= words.size() || data_ready) words.push_back(cur_word);
                else ovr_exp++;
            end
        end
        if (measure) begin
            lat0 = 0;
            lat1 = 0;
            for (int i = 1; i <= 12; i++) begin
                @(posedge clk);
                #1;
                if (valid0 && lat0 == 0) lat0 = i;
                if (valid1 && lat1 == 0) lat1 = i;
            end
            #1;
        end else begin
            waitClk(8);
        end
        sclk = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] w, input int nbits, input bit measure_last);
        for (int i = 0; i < nbits; i++) begin
            sendBit(w[7-i], measure_last && (i == nbits - 1));
        end
    endtask

    task automatic ssLow();
        ss = 1'b0;
        waitClk(8);
        if (!waiting) bit_count = 0;
    endtask

    task automatic ssHigh();
        ss = 1'b1;
        if (!waiting && (bit_count % 8) != 0) ferr_exp++;
        waitClk(12);
        waiting   = 1'b0;
        bit_count = 0;
    endtask

    task automatic endTest(input string name);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("%s_overruns_dut%0d", name, k), ovr_seen[k], ovr_exp);
            checkOutput($sformatf("%s_frame_errs_dut%0d", name, k), ferr_seen[k], ferr_exp);
            checkOutput($sformatf("%s_words_dut%0d", name, k), idx[k], words.size());
        end
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0; data_ready = 1'b1;
        waiting = 1'b1; bit_count = 0; cur_word = '0; ovr_exp = 0; ferr_exp = 0;
        lat0 = 0; lat1 = 0;
        for (int k = 0; k < 2; k++) begin
            idx[k] = 0; ovr_seen[k] = 0; ferr_seen[k] = 0;
            prev_vr[k] = 0; prev_ovr[k] = 0; prev_ferr[k] = 0; last_beat[k] = '0;
        end

        // Reset state
        waitClk(3);
        checkOutput("rst_data_out", data_out0, 8'h00);
        checkOutput("rst_valid", valid0, 0);
        checkOutput("rst_overrun", ovr0, 0);
        checkOutput("rst_frame_err", ferr0, 0);
        checkOutput("rst_busy", busy0, 0);
        checkOutput("rst_valid_s3", valid1, 0);
        rst = 1'b0;
        waitClk(10);
        waiting = 1'b0;

        // 1: single word 0xA5, consumer always ready
        ssLow();
        applyStimulus(8'hA5, 8, 1'b0);
        ssHigh();
        checkOutput("t1_model_words", words.size(), 1);
        checkOutput("t1_last_beat", last_beat[0], 8'hA5);
        checkOutput("t1_last_beat_s3", last_beat[1], 8'hA5);
        checkOutput("t1_data_out", data_out0, 8'hA5);
        checkOutput("t1_valid_dropped", valid0, 0);
        endTest("t1");

        // 2: three back-to-back words in one frame
        ssLow();
        checkOutput("t2_busy_start", busy0, 1);
        checkOutput("t2_busy_start_s3", busy1, 1);
        applyStimulus(8'h3C, 8, 1'b0);
        applyStimulus(8'hC3, 8, 1'b0);
        checkOutput("t2_busy_mid", busy0, 1);
        applyStimulus(8'hFF, 8, 1'b0);
        checkOutput("t2_busy_end", busy0, 1);
        checkOutput("t2_busy_end_s3", busy1, 1);
        ssHigh();
        checkOutput("t2_busy_after", busy0, 0);
        checkOutput("t2_busy_after_s3", busy1, 0);
        checkOutput("t2_model_words", words.size(), 4);
        checkOutput("t2_last_beat", last_beat[0], 8'hFF);
        endTest("t2");

        // 3: consumer stalled, second word overruns
        data_ready = 1'b0;
        ssLow();
        applyStimulus(8'h11, 8, 1'b0);
        applyStimulus(8'h22, 8, 1'b0);
        ssHigh();
        checkOutput("t3_held_data", data_out0, 8'h11);
        checkOutput("t3_held_valid", valid0, 1);
        checkOutput("t3_held_data_s3", data_out1, 8'h11);
        checkOutput("t3_overruns", ovr_seen[0], 1);
        checkOutput("t3_overruns_s3", ovr_seen[1], 1);
        checkOutput("t3_model_words", words.size(), 5);
        data_ready = 1'b1;
        waitClk(4);
        checkOutput("t3_valid_cleared", valid0, 0);
        checkOutput("t3_valid_cleared_s3", valid1, 0);
        checkOutput("t3_consumed", last_beat[0], 8'h11);
        endTest("t3");

        // 4: frame aborted after 5 bits, then a clean word
        ssLow();
        applyStimulus(8'h96, 5, 1'b0);
        ssHigh();
        checkOutput("t4_frame_errs", ferr_seen[0], 1);
        checkOutput("t4_frame_errs_s3", ferr_seen[1], 1);
        checkOutput("t4_model_words", words.size(), 5);
        ssLow();
        applyStimulus(8'h5A, 8, 1'b0);
        ssHigh();
        checkOutput("t4_last_beat", last_beat[0], 8'h5A);
        checkOutput("t4_last_beat_s3", last_beat[1], 8'h5A);
        endTest("t4");

        // 5: reset mid-frame with ss held low
        ssLow();
        applyStimulus(8'hF0, 4, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t5_rst_busy", busy0, 0);
        checkOutput("t5_rst_data_out", data_out0, 8'h00);
        checkOutput("t5_rst_valid", valid0, 0);
        rst = 1'b0;
        waiting = 1'b1;
        bit_count = 0;
        for (int k = 0; k < 2; k++) begin
            idx[k] = words.size();
            prev_vr[k] = 0; prev_ovr[k] = 0; prev_ferr[k] = 0;
        end
        applyStimulus(8'h00, 4, 1'b0);
        checkOutput("t5_wait_not_busy", busy0, 0);
        checkOutput("t5_wait_not_busy_s3", busy1, 0);
        ssHigh();
        ssLow();
        applyStimulus(8'h81, 8, 1'b0);
        ssHigh();
        checkOutput("t5_last_beat", last_beat[0], 8'h81);
        checkOutput("t5_data_out", data_out0, 8'h81);
        checkOutput("t5_data_out_s3", data_out1, 8'h81);
        endTest("t5");

        // 6: latency from final sclk rise to data_valid
        ssLow();
        applyStimulus(8'hC9, 8, 1'b1);
        ssHigh();
        $display("[TB] latency: %0d edges (2 stages), %0d edges (3 stages)", lat0, lat1);
        checkOutput("t6_latency_s2", (lat0 >= 1 && lat0 <= 4), 1);
        checkOutput("t6_latency_s3", (lat1 >= 1 && lat1 <= 5), 1);
        checkOutput("t6_last_beat", last_beat[0], 8'hC9);
        endTest("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
